// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with stall, flush and occupancy count.
// Define PIPE_SKID_BUF_EN to add a one-entry input skid register that registers in_ready.
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          stall,
    input  logic                          flush,
    output logic [$clog2(STAGES+2)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(STAGES+2);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] acc_s;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic              src_v_s;
    logic [WIDTH-1:0]  src_d_s;
    logic              skid_cnt_s;

    // Accept chain: a stage accepts if empty or if everything downstream moves.
    always_comb begin
        logic a;
        a = !v_q[STAGES-1] || out_ready;
        acc_s = '0;
        acc_s[STAGES-1] = a;
        for (int i = STAGES-2; i >= 0; i--) begin
            a = !v_q[i] || a;
            acc_s[i] = a;
        end
    end

`ifdef PIPE_SKID_BUF_EN
    logic             skid_v_q;
    logic             skid_v_d;
    logic [WIDTH-1:0] skid_d_q;
    logic [WIDTH-1:0] skid_d_d;
    logic             take_s;

    // Skid control: a parked item always enters stage 0 ahead of new input.
    always_comb begin
        take_s   = acc_s[0] && !stall && !flush;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            if (take_s) begin
                skid_v_d = 1'b0;
            end else begin
                skid_v_d = 1'b1;
            end
        end else if (in_valid && !take_s) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
        end else begin
            skid_v_d = 1'b0;
        end
        src_v_s    = skid_v_q || in_valid;
        src_d_s    = skid_v_q ? skid_d_q : in_data;
        in_ready   = rst && !skid_v_q && !flush;
        skid_cnt_s = skid_v_d;
    end

    // Skid register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_v_q <= 1'b0;
            skid_d_q <= '0;
        end else begin
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end
`else
    // Stage 0 is fed straight from the input port.
    always_comb begin
        src_v_s    = in_valid;
        src_d_s    = in_data;
        in_ready   = rst && acc_s[0] && !stall && !flush;
        skid_cnt_s = 1'b0;
    end
`endif

    // Next-state for every stage; data only moves with a valid item.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
        end else if (!stall) begin
            if (acc_s[0]) begin
                v_d[0] = src_v_s;
                if (src_v_s) begin
                    d_d[0] = src_d_s;
                end else begin
                    d_d[0] = d_q[0];
                end
            end else begin
                v_d[0] = v_q[0];
            end
            for (int i = 1; i < STAGES; i++) begin
                if (acc_s[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        d_d[i] = d_q[i-1];
                    end else begin
                        d_d[i] = d_q[i];
                    end
                end else begin
                    v_d[i] = v_q[i];
                end
            end
        end else begin
            v_d = v_q;
        end
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(v_d[i]);
        end
        occ_d = occ_d + OCC_W'(skid_cnt_s);
    end

    // Stage registers and occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign out_valid = v_q[STAGES-1] && !stall && !flush;
    assign out_data  = d_q[STAGES-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (default build, STAGES=4) with an in-order scoreboard.
module tb_pipe_stage_chain;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int OW     = $clog2(STAGES+2);

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             stall     = 1'b0;
    logic             flush     = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [OW-1:0]    occupancy;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] sb [$];

    pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall     (stall),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted items, compare every delivered item in order.
    always @(negedge clk) begin
        if (!rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk_b("sb_has_item", sb.size() != 0, 1'b1);
                if (sb.size() != 0) chk_w("sb_order", out_data, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        // Reset state while rst is low
        #2;
        chk_b("rst_in_ready", in_ready, 1'b0);
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_w("rst_occupancy", 32'(occupancy), 32'd0);
        chk_w("rst_out_data", out_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single item latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) chk_b("t1_in_ready", in_ready, 1'b1);
            chk_b("t1_out_valid", out_valid, (k == 4));
            if (k == 4) chk_w("t1_out_data", out_data, 32'h11);
            nxt();
            in_valid = 1'b0;
        end

        // Back-to-back stream 1..8
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            in_data  = 32'(c + 1);
            @(negedge clk);
            if (c < 8) chk_b("t2_in_ready", in_ready, 1'b1);
            chk_b("t2_out_valid", out_valid, (c >= 4 && c <= 11));
            if (c >= 4 && c <= 11) chk_w("t2_out_data", out_data, 32'(c - 3));
            nxt();
        end
        in_valid = 1'b0;

        // Fill with backpressure, then drain
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hA + 32'(c);
            @(negedge clk);
            chk_b("t3_fill_ready", in_ready, 1'b1);
            nxt();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk_w("t3_occ_full", 32'(occupancy), 32'd4);
        chk_b("t3_in_ready_full", in_ready, 1'b0);
        chk_b("t3_out_valid_full", out_valid, 1'b1);
        chk_w("t3_head", out_data, 32'hA);
        nxt();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_b("t3_drain_valid", out_valid, (c < 4));
            if (c < 4) chk_w("t3_drain_data", out_data, 32'hA + 32'(c));
            if (c == 4) chk_w("t3_occ_empty", 32'(occupancy), 32'd0);
            nxt();
        end

        // Flush with three items in flight
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h21 + 32'(c);
            @(negedge clk);
            nxt();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        chk_b("t4_flush_in_ready", in_ready, 1'b0);
        chk_b("t4_flush_out_valid", out_valid, 1'b0);
        chk_w("t4_occ_before", 32'(occupancy), 32'd3);
        nxt();
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h55;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) chk_w("t4_occ_after", 32'(occupancy), 32'd0);
            chk_b("t4_out_valid", out_valid, (k == 4));
            if (k == 4) chk_w("t4_out_data", out_data, 32'h55);
            nxt();
            in_valid = 1'b0;
        end

        // Stall held 3 cycles mid-stream
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (idx < 8);
            in_data  = 32'h31 + 32'(idx);
            stall    = (c >= 5 && c <= 7);
            @(negedge clk);
            if (stall) begin
                chk_b("t5_stall_in_ready", in_ready, 1'b0);
                chk_b("t5_stall_out_valid", out_valid, 1'b0);
            end
            if (c >= 5 && c <= 8) begin
                chk_w("t5_stall_occ", 32'(occupancy), 32'd4);
                chk_w("t5_stall_data", out_data, 32'h32);
            end
            if (in_valid && in_ready) idx++;
            nxt();
        end
        stall    = 1'b0;
        in_valid = 1'b0;
        chk_w("t5_accepted", 32'(idx), 32'd8);

        // Asynchronous reset with two items held
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h41 + 32'(c);
            @(negedge clk);
            nxt();
        end
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            nxt();
        end
        @(negedge clk);
        chk_b("t6_held_valid", out_valid, 1'b1);
        chk_w("t6_held_occ", 32'(occupancy), 32'd2);
        chk_w("t6_held_data", out_data, 32'h41);
        nxt();
        rst = 1'b0;
        #1;
        chk_b("t6_async_out_valid", out_valid, 1'b0);
        chk_b("t6_async_in_ready", in_ready, 1'b0);
        chk_w("t6_async_occ", 32'(occupancy), 32'd0);
        chk_w("t6_async_out_data", out_data, 32'h0);
        nxt();
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h66;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) chk_b("t6_rel_in_ready", in_ready, 1'b1);
            if (k == 1) chk_w("t6_rel_occ", 32'(occupancy), 32'd1);
            chk_b("t6_rel_out_valid", out_valid, (k == 4));
            if (k == 4) chk_w("t6_rel_out_data", out_data, 32'h66);
            nxt();
            in_valid = 1'b0;
        end

        chk_w("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload bits per stage (legal 1..256).
REQ-002 SHALL have parameter STAGES, default 4, meaning number of register stages (legal 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream item present.
REQ-006 SHALL have port in_ready  output  1  chain accepts an item this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  last stage holds a deliverable item.
REQ-009 SHALL have port out_ready  input  1  downstream accepts an item.
REQ-010 SHALL have port out_data  output  WIDTH  last-stage payload.
REQ-011 SHALL have port stall  input  1  freeze every stage.
REQ-012 SHALL have port flush  input  1  discard every held item.
REQ-013 SHALL have port occupancy  output  $clog2(STAGES+2)  count of valid entries held.

Function
REQ-014 SHALL hold a valid bit v[i] and a data word d[i] per stage i, for i = 0..STAGES-1, where stage STAGES-1 drives out_data.
REQ-015 SHALL compute acc[STAGES-1] = !v[STAGES-1] || out_ready.
REQ-016 SHALL compute acc[i] = !v[i] || acc[i+1] for every other stage, so bubbles collapse and an empty stage always accepts.
REQ-017 SHALL, when acc[i] is high and stall and flush are low, load v[i] and d[i] from stage i-1, or from in_valid/in_data for stage 0, on the next edge.
REQ-018 SHALL leave d[i] unchanged whenever v[i] is cleared, and SHALL capture no data while stall is high.
REQ-019 SHALL drive in_ready = acc[0] && !stall && !flush, combinationally.
REQ-020 SHALL drive out_valid = v[STAGES-1] && !stall && !flush.
REQ-021 SHALL complete a transfer only when valid and ready are both high in the same cycle, on both the input and the output side.
REQ-022 SHALL, for an item accepted into an empty chain, assert out_valid exactly STAGES edges after acceptance; this is the latency.
REQ-023 SHALL sustain one item per cycle while out_ready is high, with no bubble inserted.
REQ-024 SHALL clear all v[i] on the edge following a cycle with flush high; flush has priority over stall, input and output transfers, and no transfer completes in that cycle.
REQ-025 SHALL, while stall is high, hold every v[i] and d[i] unchanged.
REQ-026 SHALL make occupancy equal the population count of v plus any skid entry, updated on each edge.
REQ-027 SHALL preserve ordering: items exit in acceptance order with no duplication and no loss except by flush.

Reset
REQ-028 SHALL, while rst is low, immediately clear all v[i], clear the skid valid, and force in_ready=0, out_valid=0, occupancy=0, out_data=0.
REQ-029 SHALL, when reset is asserted mid-operation, discard all in-flight items; the first edge after release behaves as an empty chain.

Configuration
REQ-030 SHALL, when macro PIPE_SKID_BUF_EN is defined, add a one-entry input skid register.
REQ-031 SHALL, in that case, drive in_ready = !skid_valid && !flush, registered with no combinational path from out_ready; an item offered while acc[0] is low or stall is high is parked in the skid and enters stage 0 before new input; latency is unchanged when the skid is empty; flush also clears the skid.
REQ-032 SHALL, without PIPE_SKID_BUF_EN, contain no skid register, keep in_ready per REQ-019, and never count a skid entry in occupancy.

Verification
REQ-033 SHALL cover: STAGES=4, out_ready=1, push 0x11 at cycle 0 -> out_valid with out_data=0x11 at cycle 4, for one cycle.
REQ-034 SHALL cover: stream 0x1..0x8 back-to-back with out_ready=1 -> outputs 0x1..0x8 on consecutive cycles 4..11, in_ready constantly 1.
REQ-035 SHALL cover: fill with 0xA..0xD, out_ready=0 -> occupancy=4, in_ready=0; raise out_ready -> 0xA..0xD drain in order.
REQ-036 SHALL cover: three items in flight, flush pulsed 1 cycle -> occupancy=0 next cycle, out_valid never shows them, a new item 0x55 exits 4 cycles after push.
REQ-037 SHALL cover: stall held 3 cycles mid-stream -> in_ready=0 and out_valid=0 throughout, data and occupancy frozen, stream resumes intact.
REQ-038 SHALL cover: rst low for 1 cycle with 2 items held -> outputs zero asynchronously before the next edge, and no stale item appears after release.
